// File: rtl/axis_usb_tx_arbiter.sv
// axis_usb_tx_arbiter
// Merges two AXI-stream sources into one USB transmit stream. Each burst
// starts with a header word {8'hA5, 7'b0, channel, length}, followed by
// exactly 'length' data words taken from the granted channel. Ties between
// requesting channels are broken round-robin. The data path is zero-latency:
// during a burst the granted source is wired straight through to the output.
module axis_usb_tx_arbiter #(
  parameter int CNTR_WIDTH = 16,
  parameter int BURST_MAX  = 256
) (
  input  logic                  aclk,
  input  logic                  areset,

  input  logic [31:0]           s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic [CNTR_WIDTH-1:0] s0_count,

  input  logic [31:0]           s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic [CNTR_WIDTH-1:0] s1_count,

  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  // Counts are compared against BURST_MAX in a width that holds both the
  // full count and any legal BURST_MAX (up to 65535), so no wrap can occur.
  localparam int              EXT_W         = (CNTR_WIDTH > 17) ? CNTR_WIDTH : 17;
  localparam logic [EXT_W-1:0] BURST_MAX_EXT = EXT_W'(BURST_MAX);
  localparam logic [15:0]      BURST_MAX_LEN = 16'(BURST_MAX);
  localparam logic [7:0]       HDR_MAGIC     = 8'hA5;

  state_t      state_q, state_d;
  logic        grant_ch_q, grant_ch_d;
  logic        last_ch_q, last_ch_d;
  logic [15:0] len_q, len_d;
  logic [15:0] remaining_q, remaining_d;

  logic             req0, req1;
  logic             pick_ch;
  logic [CNTR_WIDTH-1:0] pick_count;
  logic [EXT_W-1:0] pick_count_ext;
  logic [15:0]      pick_len;
  logic             data_valid;
  logic [31:0]      data_word;
  logic [31:0]      header_word;

  assign req0 = (s0_count != '0);
  assign req1 = (s1_count != '0);

  // Choose the channel to serve next: a lone requester wins outright, a tie
  // goes to the channel that was not served last.
  always_comb begin
    pick_ch = 1'b0;
    if (req0 && req1) begin
      pick_ch = ~last_ch_q;
    end else if (req1) begin
      pick_ch = 1'b1;
    end
  end

  assign pick_count     = pick_ch ? s1_count : s0_count;
  assign pick_count_ext = EXT_W'(pick_count);
  // A requesting channel has a nonzero count and BURST_MAX >= 1, so the
  // clipped length is never zero.
  assign pick_len = (pick_count_ext < BURST_MAX_EXT) ? pick_count_ext[15:0] : BURST_MAX_LEN;

  // Granted source as seen by the merged stream during DATA.
  assign data_valid  = grant_ch_q ? s1_axis_tvalid : s0_axis_tvalid;
  assign data_word   = grant_ch_q ? s1_axis_tdata  : s0_axis_tdata;
  // Header is built only from registers so it stays stable under backpressure.
  assign header_word = {HDR_MAGIC, 7'b0, grant_ch_q, len_q};

  // State and burst bookkeeping registers; reset abandons any burst at once.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      grant_ch_q  <= 1'b0;
      last_ch_q   <= 1'b1;
      len_q       <= 16'd0;
      remaining_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      grant_ch_q  <= grant_ch_d;
      last_ch_q   <= last_ch_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic and stream routing for the IDLE/HEADER/DATA sequence.
  always_comb begin
    state_d        = state_q;
    grant_ch_d     = grant_ch_q;
    last_ch_d      = last_ch_q;
    len_d          = len_q;
    remaining_d    = remaining_q;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = 32'h0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Counts are sampled only here; later changes cannot alter the burst.
        if (req0 || req1) begin
          grant_ch_d = pick_ch;
          len_d      = pick_len;
          state_d    = ST_HEADER;
        end
      end

      ST_HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = header_word;
        if (m_axis_tready) begin
          remaining_d = len_q;
          state_d     = ST_DATA;
        end
      end

      ST_DATA: begin
        m_axis_tvalid  = data_valid;
        m_axis_tdata   = data_word;
        s0_axis_tready = ~grant_ch_q & m_axis_tready;
        s1_axis_tready =  grant_ch_q & m_axis_tready;
        // A source stall (tvalid low) simply waits; only handshakes count.
        if (data_valid && m_axis_tready) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            last_ch_d = grant_ch_q;
            state_d   = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axis_usb_tx_arbiter.sv
// Self-checking bench for axis_usb_tx_arbiter. Sources are modelled as word
// queues whose size drives the count inputs; the expected merged stream for
// each burst is precomputed as a queue (header then the data words) at the
// moment the arbiter should grant, and every cycle is compared against it.
module tb_axis_usb_tx_arbiter;
  localparam int CW = 16;
  localparam int BM = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic [31:0]   s0_axis_tdata, s1_axis_tdata;
  logic          s0_axis_tvalid, s1_axis_tvalid;
  logic          s0_axis_tready, s1_axis_tready;
  logic [CW-1:0] s0_count, s1_count;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          busy;

  always #5 aclk = ~aclk;

  axis_usb_tx_arbiter #(.CNTR_WIDTH(CW), .BURST_MAX(BM)) dut (
    .aclk(aclk), .areset(areset),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tready(s0_axis_tready), .s0_count(s0_count),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tready(s1_axis_tready), .s1_count(s1_count),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .busy(busy)
  );

  logic [31:0] src0_q[$];
  logic [31:0] src1_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] hdr_log[$];
  bit hdr_sent, g, last_ch, v0, v1, rdy, exp_mv, stall0;
  int vprob, push_prob, rdy_mode, data_hs, busy_cnt;
  int vectors, miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] hdr_at(input int i);
    return (i < hdr_log.size()) ? hdr_log[i] : 32'hDEADBEEF;
  endfunction

  task automatic drive();
    if (push_prob > 0 && $urandom_range(99) < push_prob) begin
      if ($urandom_range(1) == 1) src1_q.push_back($urandom());
      else src0_q.push_back($urandom());
    end
    s0_count = CW'(src0_q.size());
    s1_count = CW'(src1_q.size());
    v0 = (src0_q.size() != 0) && !stall0 && ($urandom_range(99) < vprob);
    v1 = (src1_q.size() != 0) && ($urandom_range(99) < vprob);
    s0_axis_tvalid = v0;
    s1_axis_tvalid = v1;
    s0_axis_tdata  = (src0_q.size() != 0) ? src0_q[0] : $urandom();
    s1_axis_tdata  = (src1_q.size() != 0) ? src1_q[0] : $urandom();
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = ~rdy;
      default: rdy = ($urandom_range(1) == 1);
    endcase
    m_axis_tready = rdy;
  endtask

  task automatic check_outputs();
    bit idle;
    idle   = (exp_q.size() == 0);
    exp_mv = idle ? 1'b0 : (!hdr_sent ? 1'b1 : (g ? v1 : v0));
    chk("busy", 32'(busy), 32'(!idle));
    chk("m_tvalid", 32'(m_axis_tvalid), 32'(exp_mv));
    chk("s0_tready", 32'(s0_axis_tready), 32'(!idle && hdr_sent && !g && rdy));
    chk("s1_tready", 32'(s1_axis_tready), 32'(!idle && hdr_sent && g && rdy));
    if (exp_mv) chk("m_tdata", m_axis_tdata, exp_q[0]);
    if (busy) busy_cnt++;
    if (m_axis_tvalid && m_axis_tready && !idle) begin
      if (!hdr_sent) hdr_log.push_back(m_axis_tdata);
      else data_hs++;
    end
  endtask

  // Burst-level reference: on an idle cycle with any nonempty source, build
  // the whole expected burst from the source contents; otherwise consume it.
  task automatic update_model();
    int n, len;
    if (exp_q.size() == 0) begin
      if (src0_q.size() != 0 || src1_q.size() != 0) begin
        if (src0_q.size() != 0 && src1_q.size() != 0) g = ~last_ch;
        else g = (src0_q.size() == 0);
        n   = g ? src1_q.size() : src0_q.size();
        len = (n < BM) ? n : BM;
        exp_q.push_back({8'hA5, 7'b0, g, 16'(len)});
        for (int i = 0; i < len; i++) exp_q.push_back(g ? src1_q[i] : src0_q[i]);
        hdr_sent = 1'b0;
        data_hs  = 0;
      end
    end else if (exp_mv && rdy) begin
      void'(exp_q.pop_front());
      if (!hdr_sent) hdr_sent = 1'b1;
      else if (g) void'(src1_q.pop_front());
      else void'(src0_q.pop_front());
      if (exp_q.size() == 0) last_ch = g;
    end
  endtask

  task automatic step_body();
    drive();
    #1;
    check_outputs();
    @(posedge aclk);
    update_model();
  endtask

  task automatic step();
    @(negedge aclk);
    step_body();
  endtask

  task automatic do_reset(input int n);
    @(negedge aclk);
    areset = 1'b1;
    #1;
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_s0_tready", 32'(s0_axis_tready), 32'd0);
    chk("rst_s1_tready", 32'(s1_axis_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    hdr_sent = 1'b0;
    last_ch  = 1'b1;
    repeat (n) @(negedge aclk);
    areset = 1'b0;
    step_body();
  endtask

  initial begin
    int k;
    vectors = 0; miscompares = 0;
    areset = 1'b1;
    s0_axis_tdata = '0; s1_axis_tdata = '0;
    s0_axis_tvalid = 1'b0; s1_axis_tvalid = 1'b0;
    s0_count = '0; s1_count = '0; m_axis_tready = 1'b0;
    rdy_mode = 0; vprob = 100; push_prob = 0; stall0 = 1'b0;
    last_ch = 1'b1; rdy = 1'b1; hdr_sent = 1'b0; g = 1'b0;
    data_hs = 0; busy_cnt = 0;
    repeat (2) @(posedge aclk);
    do_reset(2);

    // Single channel burst of 3 words.
    repeat (3) src0_q.push_back($urandom());
    hdr_log.delete(); busy_cnt = 0;
    repeat (8) step();
    chk("single_hdr_n", 32'(hdr_log.size()), 32'd1);
    chk("single_hdr", hdr_at(0), 32'hA5000003);
    chk("single_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("single_words", 32'(data_hs), 32'd3);

    // Tie after reset: channel 0 first, then channel 1.
    repeat (2) src0_q.push_back($urandom());
    repeat (2) src1_q.push_back($urandom());
    hdr_log.delete();
    do_reset(1);
    repeat (12) step();
    chk("tie_hdr_n", 32'(hdr_log.size()), 32'd2);
    chk("tie_hdr0", hdr_at(0), 32'hA5000002);
    chk("tie_hdr1", hdr_at(1), 32'hA5010002);

    // Length clip at BURST_MAX=4 with 10 words queued on channel 1.
    repeat (10) src1_q.push_back($urandom());
    hdr_log.delete();
    repeat (25) step();
    chk("clip_hdr_n", 32'(hdr_log.size()), 32'd3);
    chk("clip_hdr0", hdr_at(0), 32'hA5010004);
    chk("clip_hdr1", hdr_at(1), 32'hA5010004);
    chk("clip_hdr2", hdr_at(2), 32'hA5010002);

    // Downstream backpressure toggling every cycle, both channels pending.
    rdy_mode = 1;
    repeat (3) src0_q.push_back($urandom());
    repeat (2) src1_q.push_back($urandom());
    hdr_log.delete();
    repeat (30) step();
    chk("bp_hdr_n", 32'(hdr_log.size()), 32'd2);
    chk("bp_hdr0", hdr_at(0), 32'hA5000003);
    chk("bp_hdr1", hdr_at(1), 32'hA5010002);
    rdy_mode = 0;

    // Reset after two data words; the restart reflects the remaining count.
    repeat (5) src0_q.push_back($urandom());
    hdr_log.delete();
    repeat (4) step();
    do_reset(1);
    repeat (10) step();
    chk("rst_hdr_n", 32'(hdr_log.size()), 32'd2);
    chk("rst_hdr0", hdr_at(0), 32'hA5000004);
    chk("rst_hdr1", hdr_at(1), 32'hA5000003);
    chk("rst_words", 32'(data_hs), 32'd3);

    // Granted source stalls for 10 cycles in the middle of a burst.
    repeat (4) src0_q.push_back($urandom());
    hdr_log.delete();
    repeat (3) step();
    stall0 = 1'b1;
    repeat (10) step();
    stall0 = 1'b0;
    repeat (10) step();
    chk("stall_hdr", hdr_at(0), 32'hA5000004);
    chk("stall_words", 32'(data_hs), 32'd4);

    // Randomized traffic with a reset in the middle, then drain.
    rdy_mode = 2; vprob = 70; push_prob = 40;
    repeat (300) step();
    do_reset(1);
    repeat (300) step();
    push_prob = 0;
    k = 0;
    while ((src0_q.size() != 0 || src1_q.size() != 0 || exp_q.size() != 0) && k < 2000) begin
      step();
      k++;
    end
    chk("drain_timeout", 32'(k < 2000), 32'd1);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_usb_tx_arbiter.md
AXIS_USB_TX_ARBITER -- requirements
Module: axis_usb_tx_arbiter

Interface
REQ-001 Parameter: CNTR_WIDTH, default 16, width of the channel word-count inputs.
REQ-002 Parameter: BURST_MAX, default 256, maximum data words per burst; legal range 1..65535.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 Port aclk  input  1  the single clock; all logic is on its rising edge.
REQ-005 Port areset  input  1  asynchronous active-high reset.
REQ-006 Port s0_axis_tdata  input  32  channel 0 data word.
REQ-007 Port s0_axis_tvalid  input  1  channel 0 word valid.
REQ-008 Port s0_axis_tready  output  1  channel 0 word accepted.
REQ-009 Port s0_count  input  CNTR_WIDTH  words buffered upstream on channel 0; it only decreases through handshakes on this block.
REQ-010 Ports s1_axis_tdata, s1_axis_tvalid, s1_axis_tready and s1_count SHALL be identical in width and meaning to the channel 0 ports, applied to channel 1.
REQ-011 Port m_axis_tdata  output  32  merged stream word, feeding the USB transmit path.
REQ-012 Port m_axis_tvalid  output  1  merged word valid.
REQ-013 Port m_axis_tready  input  1  downstream accepts the word.
REQ-014 Port busy  output  1  high in HEADER and DATA states.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, HEADER and DATA.
REQ-016 Request definition: req_i = (si_count != 0).
REQ-017 IDLE, no request: remain in IDLE; m_axis_tvalid=0; both s*_axis_tready=0.
REQ-018 IDLE, request present:
- If exactly one req is high, grant that channel.
- If both are high, grant the channel other than last_ch (round-robin).
- On the next edge, register grant_ch and len = min(count_grant, BURST_MAX) clipped to 16 bits, then enter HEADER.
REQ-019 HEADER output:
- m_axis_tvalid=1.
- m_axis_tdata = {8'hA5, 7'b0, grant_ch, len[15:0]}, driven from registers.
- Both s*_axis_tready=0.
REQ-020 HEADER, on m_axis handshake: load remaining=len and enter DATA. Without a handshake, hold tdata stable (AXI-stream rule).
REQ-021 DATA routing:
- m_axis_tdata and m_axis_tvalid come combinationally from the granted channel.
- sG_axis_tready = m_axis_tready for the granted channel.
- The non-granted tready SHALL be 0.
REQ-022 DATA, on each handshake: decrement remaining. A handshake with remaining==1 SHALL:
- set last_ch=grant_ch,
- enter IDLE on the next edge.
REQ-023 Zero-latency path in DATA; a granted tvalid=0 stall SHALL NOT end the burst.
REQ-024 Back-to-back: IDLE inserts exactly one cycle between bursts, with m_axis_tvalid=0.
REQ-025 Count changes after the grant SHALL NOT alter len; the count is sampled only in IDLE.
REQ-026 The burst length SHALL never exceed BURST_MAX and SHALL never be 0.
REQ-027 Each burst carries exactly len data words, and no word from the non-granted channel enters the burst.
REQ-028 busy = (state != IDLE).

Reset
REQ-029 areset high SHALL immediately force:
- state=IDLE, last_ch=1 (so channel 0 wins the first tie),
- len=0, remaining=0,
- m_axis_tvalid=0, all s*_axis_tready=0, busy=0.
REQ-030 Assertion mid-burst SHALL abandon the burst; no partial completion after release.
REQ-031 After deassertion, arbitration SHALL restart from IDLE on the first rising edge.

Verification
REQ-032 Single channel: s0_count=3, s1_count=0, m_axis_tready=1 -> header 0xA5000003, then 3 channel-0 words, then IDLE; busy high for 4 cycles.
REQ-033 Tie round-robin: both counts=2 after reset -> channel 0 burst (header 0xA5000002), IDLE cycle, channel 1 burst (header 0xA5010002).
REQ-034 Length clip: BURST_MAX=4, s1_count=10 -> three bursts:
- header 0xA5010004, 4 words;
- header 0xA5010004, 4 words;
- header 0xA5010002, 2 words.
REQ-035 Backpressure: m_axis_tready toggles 1/0 every cycle during HEADER and DATA -> tdata held stable while stalled; no word lost or duplicated; s1_axis_tready stays 0 during a channel 0 burst.
REQ-036 Reset mid-burst: areset asserted after 2 of 5 words -> outputs go to reset values immediately; after release a fresh header is issued with the current count.
REQ-037 Source stall: granted tvalid low for 10 cycles mid-burst -> state remains DATA, m_axis_tvalid=0, and the burst completes with the correct word count.
